// File: rtl/fsk_modulador_if.sv
// Handshake/sample bundle between a word source and the FSK modulator.
// The source drives data_in/start; the modulator returns ready/done/status
// and the registered 8-bit sine sample stream.
interface fsk_modulador_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data_in;
    logic              start;
    logic              ready;
    logic [7:0]        out_signal;
    logic              status;
    logic              done;

    modport master (
        output data_in,
        output start,
        input  ready,
        input  out_signal,
        input  status,
        input  done
    );

    modport slave (
        input  data_in,
        input  start,
        output ready,
        output out_signal,
        output status,
        output done
    );
endinterface

// File: rtl/fsk_modulador.sv
// FSK modulator: serialises a word MSB first into 8-bit unsigned sine samples,
// one per clock. A '1' bit is one full sine cycle per bit period, a '0' bit is
// half a cycle, and the phase carries over bit and word boundaries.
// Optional build macro FSK_MOD_PREAMBLE_EN adds four '1' bit periods before
// every word that starts from idle.
//
// state  | meaning
// S_IDLE | output parked at midscale, phase held at 0 or 32, ready for a word
// S_PRE  | preamble: four full-cycle bit periods (macro builds only)
// S_DATA | emitting the word held in the shift register, MSB first
module fsk_modulador #(
    parameter int         DATA_W      = 16,
    parameter int         BIT_CLKS    = 32,
    parameter logic [7:0] IDLE_SAMPLE = 8'd128
) (
    input  logic              G_CLK_TX,
    input  logic              reset,
    fsk_modulador_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [4:0] LAST_CLK  = 5'(BIT_CLKS - 1);
    localparam logic [3:0] FIRST_BIT = 4'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [5:0]          r_phase;
    logic [DATA_W-1:0]   r_shreg;
    logic [3:0]          r_bitcnt;
    logic [4:0]          r_clkcnt;
    logic [7:0]          r_out;
    logic                r_status;
`ifdef FSK_MOD_PREAMBLE_EN
    logic [1:0]          r_pre_cnt;
`endif

    logic w_last_clk;
    logic w_final_clk;
    logic w_ready;
    logic w_done;
    logic w_accept;

    // Quarter-wave symmetric table: the second half is the mirror around 128.
    function automatic logic [7:0] sine_lut(input logic [4:0] idx);
        logic [7:0] q;
        case (idx[3:0])
            4'd0:    q = 8'd128;
            4'd1:    q = 8'd153;
            4'd2:    q = 8'd177;
            4'd3:    q = 8'd199;
            4'd4:    q = 8'd218;
            4'd5:    q = 8'd234;
            4'd6:    q = 8'd246;
            4'd7:    q = 8'd253;
            4'd8:    q = 8'd255;
            4'd9:    q = 8'd253;
            4'd10:   q = 8'd246;
            4'd11:   q = 8'd234;
            4'd12:   q = 8'd218;
            4'd13:   q = 8'd199;
            4'd14:   q = 8'd177;
            default: q = 8'd153;
        endcase
        if (idx[4]) begin
            q = 8'(9'd256 - {1'b0, q});
        end
        return q;
    endfunction

    assign w_last_clk  = (r_clkcnt == LAST_CLK);
    assign w_final_clk = (r_bitcnt == 4'd0) && w_last_clk;
    assign w_accept    = bus.start && w_ready;

    // State register.
    always_ff @(posedge G_CLK_TX) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a start on the final data cycle chains straight into the next word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef FSK_MOD_PREAMBLE_EN
                    w_state_nxt = S_PRE;
`else
                    w_state_nxt = S_DATA;
`endif
                end
            end
`ifdef FSK_MOD_PREAMBLE_EN
            S_PRE: begin
                if ((r_pre_cnt == 2'd3) && w_last_clk) begin
                    w_state_nxt = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (w_final_clk) begin
                    w_state_nxt = w_accept ? S_DATA : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: ready in idle and on the last data cycle, done only on the latter.
    always_comb begin
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: w_ready = 1'b1;
            S_DATA: begin
                if (w_final_clk) begin
                    w_ready = 1'b1;
                    w_done  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath: phase accumulator, bit/clock counters, shift register and sample register.
    always_ff @(posedge G_CLK_TX) begin
        if (reset) begin
            r_phase   <= 6'd0;
            r_shreg   <= '0;
            r_bitcnt  <= 4'd0;
            r_clkcnt  <= 5'd0;
            r_out     <= IDLE_SAMPLE;
            r_status  <= 1'b0;
`ifdef FSK_MOD_PREAMBLE_EN
            r_pre_cnt <= 2'd0;
`endif
        end else begin
            // status follows the sample register, one cycle behind the state
            r_status <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_out <= IDLE_SAMPLE;
                    if (w_accept) begin
                        r_shreg   <= bus.data_in;
                        r_bitcnt  <= FIRST_BIT;
                        r_clkcnt  <= 5'd0;
`ifdef FSK_MOD_PREAMBLE_EN
                        r_pre_cnt <= 2'd0;
`endif
                    end
                end
`ifdef FSK_MOD_PREAMBLE_EN
                S_PRE: begin
                    r_out   <= sine_lut(r_phase[5:1]);
                    r_phase <= r_phase + 6'd2;
                    if (w_last_clk) begin
                        r_clkcnt  <= 5'd0;
                        r_pre_cnt <= r_pre_cnt + 2'd1;
                    end else begin
                        r_clkcnt  <= r_clkcnt + 5'd1;
                    end
                end
`endif
                S_DATA: begin
                    r_out   <= sine_lut(r_phase[5:1]);
                    r_phase <= r_phase + (r_shreg[DATA_W-1] ? 6'd2 : 6'd1);
                    if (w_last_clk) begin
                        r_clkcnt <= 5'd0;
                        if (r_bitcnt == 4'd0) begin
                            if (w_accept) begin
                                r_shreg  <= bus.data_in;
                                r_bitcnt <= FIRST_BIT;
                            end
                        end else begin
                            r_shreg  <= {r_shreg[DATA_W-2:0], 1'b0};
                            r_bitcnt <= r_bitcnt - 4'd1;
                        end
                    end else begin
                        r_clkcnt <= r_clkcnt + 5'd1;
                    end
                end
                default: r_out <= IDLE_SAMPLE;
            endcase
        end
    end

    assign bus.ready      = w_ready;
    assign bus.done       = w_done;
    assign bus.out_signal = r_out;
    assign bus.status     = r_status;

endmodule

// File: tb/tb_fsk_modulador.sv
// Bench for fsk_modulador: directed words plus random start/data traffic,
// compared every cycle against a sample-stream reference model.
module tb_fsk_modulador;

`ifdef FSK_MOD_PREAMBLE_EN
    localparam int PRE_CLKS = 128;
`else
    localparam int PRE_CLKS = 0;
`endif
    localparam int WORD_CLKS = PRE_CLKS + 16 * 32;

    logic clk_sys = 1'b0;
    logic rst_sys;

    fsk_modulador_if #(.DATA_W(16)) bus ();

    fsk_modulador dut (
        .G_CLK_TX (clk_sys),
        .reset    (rst_sys),
        .bus      (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int g_done_cnt = 0;

    // reference model: pending sample stream, counter cycles left in the word, carrier phase
    int tab [32];
    int m_q [$];
    int m_busy;
    int m_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // One bit period: phase advances by 1 or 2 units of 1/64 cycle per clock.
    task automatic push_bit(input bit b);
        int step;
        step = b ? 2 : 1;
        for (int c = 0; c < 32; c++) begin
            m_q.push_back(tab[((m_phase + c * step) % 64) / 2]);
        end
        m_phase = (m_phase + 32 * step) % 64;
    endtask

    task automatic push_word(input logic [15:0] w);
        if (PRE_CLKS > 0) begin
            for (int i = 0; i < 4; i++) push_bit(1'b1);
        end
        for (int i = 15; i >= 0; i--) push_bit(w[i]);
    endtask

    // Drive one clock cycle, compare against the model before and after the edge.
    task automatic cycle(input logic s, input logic [15:0] d, input logic r);
        logic exp_ready;
        logic exp_done;
        logic acc;
        int   exp_out;
        logic exp_status;
        bus.start   = s;
        bus.data_in = d;
        rst_sys     = r;
        exp_ready = (m_busy <= 1);
        exp_done  = (m_busy == 1);
        check("ready", 32'(bus.ready), 32'(exp_ready));
        check("done", 32'(bus.done), 32'(exp_done));
        if (bus.done === 1'b1) g_done_cnt++;
        acc = s && exp_ready && !r;
        @(posedge clk_sys);
        #1;
        if (r) begin
            m_q.delete();
            m_busy     = 0;
            m_phase    = 0;
            exp_out    = 128;
            exp_status = 1'b0;
        end else begin
            exp_status = (m_busy > 0);
            if (m_busy > 0 && m_q.size() > 0) exp_out = m_q.pop_front();
            else exp_out = 128;
            if (m_busy > 0) m_busy--;
            if (acc) begin
                push_word(d);
                m_busy = WORD_CLKS;
            end
        end
        check("out_signal", 32'(bus.out_signal), 32'(exp_out));
        check("status", 32'(bus.status), 32'(exp_status));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic send_single(input logic [15:0] w);
        cycle(1'b1, w, 1'b0);
        idle(WORD_CLKS + 8);
    endtask

    initial begin
        int base [16] = '{128,153,177,199,218,234,246,253,255,253,246,234,218,199,177,153};
        for (int k = 0; k < 16; k++) begin
            tab[k]      = base[k];
            tab[k + 16] = 256 - base[k];
        end
        m_busy  = 0;
        m_phase = 0;
        rst_sys     = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 16'h0000;
        @(posedge clk_sys);
        #1;

        // 1: reset held, then quiet idle
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1);
        idle(6);

        // 2: all ones, exactly one done pulse
        g_done_cnt = 0;
        send_single(16'hFFFF);
        check("done_pulses_ffff", 32'(g_done_cnt), 32'd1);

        // 3: all zeros, half cycles
        send_single(16'h0000);

        // 4: mixed full/half cycles
        send_single(16'h8001);

        // 5: start held high across a word boundary, data changes while busy ignored
        g_done_cnt = 0;
        cycle(1'b1, 16'hA5C3, 1'b0);
        for (int i = 0; i < WORD_CLKS; i++) cycle(1'b1, 16'h3C5A, 1'b0);
        idle(WORD_CLKS + 8);
        check("done_pulses_b2b", 32'(g_done_cnt), 32'd2);

        // 6: reset at bit 7, clkcnt 10, then a fresh word from phase 0
        cycle(1'b1, 16'($urandom), 1'b0);
        idle(PRE_CLKS + 8 * 32 + 10);
        cycle(1'b0, 16'h0000, 1'b1);
        idle(3);
        send_single(16'($urandom));

        // random traffic: sparse start pulses, random data, some back-to-back hits
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 8) == 0, 16'($urandom), 1'b0);
        end
        idle(WORD_CLKS + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
